// File: rtl/matrix_pkg.sv
// Shared parameters and FSM encoding for the systolic-array operand feeder.
package matrix_pkg;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int STREAM_LEN = 3 * N - 2;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction
endpackage

// File: rtl/feed_bank.sv
// One N x N operand buffer with skewed edge-slice selection; ROW_WISE picks A (row) or B (column) skew.
module feed_bank #(
  parameter int N        = matrix_pkg::N,
  parameter int DW       = matrix_pkg::DW,
  parameter int IW       = $clog2(matrix_pkg::N),
  parameter int TW       = 4,
  parameter bit ROW_WISE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_row,
  input  logic [IW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            load,
  input  logic [TW-1:0]   t_nxt,
  output logic [N*DW-1:0] feed
);
  logic [N-1:0][N-1:0][DW-1:0] mem, mem_nxt;
  logic [N*DW-1:0]             sel;

  // Write forwarding: a write landing on the go edge is visible in the t=0 slice.
  always_comb begin
    mem_nxt = mem;
    if (wr_en) mem_nxt[wr_row][wr_col] = wr_data;
  end

  for (genvar k = 0; k < N; k++) begin : g_slice
    logic [TW:0] d;
    logic        in_rng;
    assign d      = {1'b0, t_nxt} - (TW+1)'(k);
    assign in_rng = !d[TW] && (d < (TW+1)'(N));
    assign sel[k*DW +: DW] = !in_rng ? '0 :
                             ROW_WISE ? mem_nxt[k][d[IW-1:0]] : mem_nxt[d[IW-1:0]][k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      feed <= '0;
    end else begin
      mem  <= mem_nxt;
      feed <= load ? sel : '0;
    end
  end
endmodule

// File: rtl/matrix_feeder.sv
// Streams two loaded N x N matrices into a systolic MAC grid with diagonal skew and zero padding.
module matrix_feeder #(
  parameter int N  = matrix_pkg::N,
  parameter int DW = matrix_pkg::DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DW-1:0]        wr_data,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  output logic [N*DW-1:0]      a_out,
  output logic [N*DW-1:0]      b_out,
  output logic                 mac_start
);
  import matrix_pkg::*;

  localparam int IW   = $clog2(N);
  localparam int SLEN = stream_len(N);
  localparam int TW   = $clog2(SLEN);

  state_t          state, state_nxt;
  logic [TW-1:0]   t, t_nxt;
  logic            wr_ok, stream_nxt;

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      IDLE:   if (go) begin
                state_nxt = STREAM;
                t_nxt     = '0;
              end
      STREAM: if (t == TW'(SLEN - 1)) begin
                state_nxt = DONE;
                t_nxt     = '0;
              end else begin
                t_nxt = t + 1'b1;
              end
      DONE:   state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    endcase
  end

  assign stream_nxt = (state_nxt == STREAM);
  assign wr_ok      = wr_en && (state != STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      t         <= '0;
      mac_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      t         <= t_nxt;
      mac_start <= stream_nxt;
    end
  end

  assign busy = (state == STREAM);
  assign done = (state == DONE);

  feed_bank #(.N(N), .DW(DW), .IW(IW), .TW(TW), .ROW_WISE(1'b1)) u_bank_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok && !wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .load    (stream_nxt),
    .t_nxt   (t_nxt),
    .feed    (a_out)
  );

  feed_bank #(.N(N), .DW(DW), .IW(IW), .TW(TW), .ROW_WISE(1'b0)) u_bank_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok && wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .load    (stream_nxt),
    .t_nxt   (t_nxt),
    .feed    (b_out)
  );
endmodule

// File: tb/tb_matrix_feeder.sv
// Directed/randomized bench for matrix_feeder with a matrix-level reference model and systolic-grid C check.
module tb_matrix_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int L  = 3 * N - 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            wr_en = 1'b0, wr_sel = 1'b0, go = 1'b0;
  logic [1:0]      wr_row = '0, wr_col = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            busy, done, mac_start;
  logic [N*DW-1:0] a_out, b_out;

  int A [N][N];
  int B [N][N];
  int a_cap [L][N];
  int b_cap [L][N];
  int C [N][N];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  matrix_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .go(go), .busy(busy), .done(done),
    .a_out(a_out), .b_out(b_out), .mac_start(mac_start)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] exp_a(input int t);
    logic [N*DW-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*DW +: DW] = DW'(A[i][t-i]);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] exp_b(input int t);
    logic [N*DW-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*DW +: DW] = DW'(B[t-j][j]);
    return r;
  endfunction

  task automatic wr(input bit sel, input int r, input int c, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_row = 2'(r); wr_col = 2'(c); wr_data = DW'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (sel) B[r][c] = d & 255; else A[r][c] = d & 255;
  endtask

  // mode 0: A=I, B=4r+c+1; 1: A=2,B=3; 2: all 255; 3: random
  task automatic load(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (mode)
          0: begin wr(0, r, c, (r == c) ? 1 : 0); wr(1, r, c, 4*r + c + 1); end
          1: begin wr(0, r, c, 2); wr(1, r, c, 3); end
          2: begin wr(0, r, c, 255); wr(1, r, c, 255); end
          default: begin wr(0, r, c, $urandom_range(255)); wr(1, r, c, $urandom_range(255)); end
        endcase
      end
  endtask

  // Accumulate as a downstream grid would: PE(i,j) sees a_out delayed j hops, b_out delayed i hops.
  task automatic check_grid(input string name);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc = 0, ref_c = 0;
        for (int tau = 0; tau < L; tau++)
          if (tau - j >= 0 && tau - i >= 0) acc += a_cap[tau-j][i] * b_cap[tau-i][j];
        for (int k = 0; k < N; k++) ref_c += A[i][k] * B[k][j];
        C[i][j] = acc % 256;
        chk($sformatf("%s_C%0d%0d", name, i, j), 64'(C[i][j]), 64'(ref_c % 256));
      end
  endtask

  // go_wr: write A[3][3]=7 on the go cycle; junk: wr_en 0x55 during stream; abort_t: reset at that t
  task automatic run_stream(input string name, input bit go_wr, input bit junk, input int abort_t);
    @(negedge clk);
    go = 1'b1;
    if (go_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd3; wr_col = 2'd3; wr_data = 8'd7;
      A[3][3] = 7;
    end
    @(posedge clk); #1;
    go = 1'b0; wr_en = 1'b0;
    for (int t = 0; t < L; t++) begin
      @(negedge clk);
      chk($sformatf("%s_busy_t%0d", name, t), 64'(busy), 64'd1);
      chk($sformatf("%s_mac_t%0d", name, t), 64'(mac_start), 64'd1);
      chk($sformatf("%s_done_t%0d", name, t), 64'(done), 64'd0);
      chk($sformatf("%s_a_t%0d", name, t), 64'(a_out), 64'(exp_a(t)));
      chk($sformatf("%s_b_t%0d", name, t), 64'(b_out), 64'(exp_b(t)));
      for (int k = 0; k < N; k++) begin
        a_cap[t][k] = int'(a_out[k*DW +: DW]);
        b_cap[t][k] = int'(b_out[k*DW +: DW]);
      end
      if (t == abort_t) begin
        #1 rst_n = 1'b0;
        #1;
        chk({name, "_rst_a"}, 64'(a_out), 64'd0);
        chk({name, "_rst_b"}, 64'(b_out), 64'd0);
        chk({name, "_rst_busy"}, 64'(busy), 64'd0);
        chk({name, "_rst_mac"}, 64'(mac_start), 64'd0);
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin A[r][c] = 0; B[r][c] = 0; end
        #1 rst_n = 1'b1;
        for (int c = 0; c < L; c++) begin
          @(negedge clk);
          chk($sformatf("%s_nodone_%0d", name, c), 64'({done, busy, mac_start}), 64'd0);
        end
        return;
      end
      wr_en = junk && (t < L - 1);
      if (wr_en) begin
        wr_sel = 1'($urandom); wr_row = 2'($urandom); wr_col = 2'($urandom); wr_data = 8'h55;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_post"}, 64'({busy, mac_start, a_out, b_out}), 64'd0);
    @(negedge clk);
    chk({name, "_done_clr"}, 64'(done), 64'd0);
    check_grid(name);
  endtask

  initial begin
    // Async reset asserted mid-cycle, well away from a clock edge
    #7 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mac", 64'(mac_start), 64'd0);
    chk("rst_a", 64'(a_out), 64'd0);
    chk("rst_b", 64'(b_out), 64'd0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin A[r][c] = 0; B[r][c] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 64'({busy, done, mac_start}), 64'd0);
    end

    load(0);
    run_stream("ident", 0, 0, -1);
    chk("ident_a_t0", 64'({a_cap[0][3], a_cap[0][2], a_cap[0][1], a_cap[0][0]} != 0 ?
                         {8'(a_cap[0][3]), 8'(a_cap[0][2]), 8'(a_cap[0][1]), 8'(a_cap[0][0])} : 32'hx),
        64'h0000_0001);
    chk("ident_b_t0", 64'({8'(b_cap[0][3]), 8'(b_cap[0][2]), 8'(b_cap[0][1]), 8'(b_cap[0][0])}), 64'h0000_0001);
    chk("ident_C_eq_B", 64'(C[2][1]), 64'd10);

    load(1);
    run_stream("twos", 0, 0, -1);
    chk("twos_C24", 64'(C[1][2]), 64'd24);

    load(2);
    run_stream("ovf", 0, 0, -1);
    chk("ovf_C4", 64'(C[3][3]), 64'd4);

    load(3);
    run_stream("rnd_junk", 0, 1, -1);
    run_stream("rnd_again", 0, 0, -1);

    load(3);
    run_stream("go_wr", 1, 0, -1);
    chk("go_wr_a3_t6", 64'(a_cap[6][3]), 64'd7);

    load(3);
    run_stream("abort", 0, 0, 4);

    load(3);
    run_stream("post_rst", 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
